// File: rtl/uart_oversample_voter.sv
// rtl/uart_oversample_voter.sv - oversampling majority-vote bit recovery for the UART RX path
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   prescale            clocks per bit, latched on enable rise / bit_restart
//   data_sample_enable  high while a frame is being received
//   bit_restart         one-cycle pulse realigning bit timing to index 0
//   SRL_data            raw asynchronous serial line
//   sampled_data        voted bit value, held between votes
//   sampled_valid       one-cycle pulse when sampled_data updates
//   noise_flag          samples of the last vote were not unanimous
//   bit_done            one-cycle pulse on the last clock of each bit
//   edge_count          oversample index within the bit, 0..P-1
//   cfg_error           latched prescale is too small for the sample window
module uart_oversample_voter #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int SAMPLES_NO     = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      data_sample_enable,
    input  logic                      bit_restart,
    input  logic                      SRL_data,
    output logic                      sampled_data,
    output logic                      sampled_valid,
    output logic                      noise_flag,
    output logic                      bit_done,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic                      cfg_error
);

    localparam int PW        = PRESCALE_WIDTH;
    localparam int ONES_W    = $clog2(SAMPLES_NO + 1);
    localparam int MIN_P_INT = (SAMPLES_NO + 2 > 4) ? SAMPLES_NO + 2 : 4;

    localparam logic [PW:0]       MIN_P     = (PW + 1)'(MIN_P_INT);
    localparam logic [PW-1:0]     HALF_S    = PW'(SAMPLES_NO / 2);
    localparam logic [PW-1:0]     S_M1      = PW'(SAMPLES_NO - 1);
    localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(SAMPLES_NO / 2);
    localparam logic [ONES_W-1:0] ONES_ALL  = ONES_W'(SAMPLES_NO);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;
    logic [PW-1:0]          p_lat;
    logic [PW-1:0]          p_next;
    logic                   p_legal_next;
    logic                   en_d;
    logic                   en_rise;
    logic                   realign;
    logic                   counting;
    logic [PW-1:0]          first_idx;
    logic [PW-1:0]          last_idx;
    logic [PW-1:0]          wrap_idx;
    logic [PW-1:0]          done_idx;
    logic                   in_window;
    logic [ONES_W-1:0]      ones;
    logic [ONES_W-1:0]      ones_sum;

    // Synchroniser presets to 1 so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SRL_data};
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];

    assign en_rise      = data_sample_enable & ~en_d;
    assign p_next       = (en_rise | bit_restart) ? prescale : p_lat;
    assign p_legal_next = ({1'b0, p_next} >= MIN_P);

    // cfg_error is computed from the value P_lat is about to take, so the
    // two registers always agree in the same cycle.
    assign realign  = data_sample_enable & (en_rise | bit_restart);
    assign counting = data_sample_enable & ~realign & ~cfg_error;

    assign first_idx = (p_lat >> 1) - HALF_S;
    assign last_idx  = first_idx + S_M1;
    assign wrap_idx  = p_lat - PW'(1);
    assign done_idx  = p_lat - PW'(2);
    assign in_window = (edge_count >= first_idx) && (edge_count <= last_idx);
    assign ones_sum  = ones + ONES_W'(line_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d          <= 1'b0;
            p_lat         <= '0;
            cfg_error     <= 1'b0;
            edge_count    <= '0;
            ones          <= '0;
            sampled_data  <= 1'b0;
            sampled_valid <= 1'b0;
            noise_flag    <= 1'b0;
            bit_done      <= 1'b0;
        end else begin
            en_d          <= data_sample_enable;
            p_lat         <= p_next;
            cfg_error     <= ~p_legal_next;
            sampled_valid <= 1'b0;
            bit_done      <= 1'b0;
            if (counting) begin
                edge_count <= (edge_count == wrap_idx) ? '0 : edge_count + PW'(1);
                if (edge_count == '0) begin
                    ones <= '0;
                end else if (in_window) begin
                    ones <= ones_sum;
                end
                // Vote registered off the last sample so it is visible at LAST+1.
                if (edge_count == last_idx) begin
                    sampled_valid <= 1'b1;
                    sampled_data  <= (ones_sum > ONES_HALF);
                    noise_flag    <= (ones_sum != '0) && (ones_sum != ONES_ALL);
                end
                bit_done <= (edge_count == done_idx);
            end else begin
                // Disabled, realigning or misconfigured: park at index 0.
                edge_count <= '0;
                ones       <= '0;
            end
        end
    end

endmodule

// File: doc/uart_oversample_voter.md
Name: uart_oversample_voter

Overview:
Parametrised oversampling bit recovery for the UART RX path: the next generation of the fixed 3-sample data sampler.
- Synchronises the raw serial line.
- Runs its own per-bit oversampling edge counter against a runtime prescale.
- Takes an odd, parametrised number of samples centred in the bit period and majority-votes them.
- Flags disagreement as noise.
- Sits between the RX pin and the RX FSM/deserializer, which consume sampled_valid, bit_done and edge_count.

Parameters:
PRESCALE_WIDTH, 6, width of prescale and edge_count (max ratio 2^PRESCALE_WIDTH-1).
SAMPLES_NO, 3, samples voted per bit; odd, 1..7.
SYNC_STAGES, 2, flops in the SRL_data synchroniser; 2..4.

Ports:
clk  in  1  system clock; all flops on rising edge.
rst  in  1  asynchronous, active-low reset.
prescale  in  PRESCALE_WIDTH  oversampling ratio (clocks per bit); latched, not live.
data_sample_enable  in  1  high while the RX FSM is receiving a frame.
bit_restart  in  1  one-cycle pulse at the detected start edge; realigns the bit timing.
SRL_data  in  1  raw asynchronous serial line.
sampled_data  out  1  voted bit value; held until the next vote.
sampled_valid  out  1  one-cycle pulse when sampled_data updates.
noise_flag  out  1  valid with sampled_valid: the samples were not unanimous.
bit_done  out  1  one-cycle pulse on the last clock of each bit period.
edge_count  out  PRESCALE_WIDTH  current oversample index within the bit, 0..P-1.
cfg_error  out  1  latched prescale is illegal.

Behaviour:
- Reset (rst low, async): all outputs 0. Synchroniser flops preset to 1 (line idle). P_lat=0, vote accumulator cleared.
- Synchroniser: line_s = SRL_data delayed SYNC_STAGES clocks. Only line_s is sampled.
- Prescale latch: P_lat <= prescale on the rising edge of data_sample_enable and on any bit_restart.
- P_lat is legal iff P_lat >= SAMPLES_NO+2 and P_lat >= 4.
- cfg_error = !legal(P_lat), registered.
- While cfg_error is set: edge_count is held at 0, no sampled_valid, no bit_done pulses.
- Window constants from P_lat: FIRST = P_lat/2 - SAMPLES_NO/2 (integer division); LAST = FIRST+SAMPLES_NO-1.
- Edge counter, enabled and legal: edge_count increments each clock and wraps P_lat-1 -> 0.
- bit_done = 1 exactly in the cycle edge_count == P_lat-1.
- Sampling: in each cycle with FIRST <= edge_count <= LAST, ones <= ones + line_s.
- ones is cleared when edge_count == 0.
- Vote: in the cycle edge_count == LAST+1, sampled_valid=1, sampled_data=(ones_final > SAMPLES_NO/2) and noise_flag=(ones_final!=0 && ones_final!=SAMPLES_NO). ones_final includes the sample taken at LAST.
- sampled_data holds between votes. noise_flag holds with it.
- Legality guarantees LAST+1 <= P_lat-1, so the vote always precedes bit_done within the same bit.
- bit_restart (with enable): next cycle edge_count=0, ones cleared, any pending vote cancelled.
- bit_restart has priority over the increment and the wrap. It is ignored when enable is low.
- Disable (data_sample_enable low): edge_count=0, ones=0, no pulses. sampled_data and noise_flag hold.
- Mid-bit disable then re-enable: counting restarts from 0; no stale vote is produced.
- Simultaneous bit_restart and edge_count==LAST+1: restart wins, sampled_valid still fires for the completed vote that cycle.
- Prescale input changes outside the latch points have no effect.
- Reset mid-bit: immediate return to reset values.
- Latency: line transition to first possible sample = SYNC_STAGES clocks. Vote is available 1 clock after the last sample.

Test Plan:
1. P=8, S=3, line held 0 for a full bit after bit_restart: FIRST=3, LAST=5. sampled_valid at edge_count=6, sampled_data=0, noise_flag=0. bit_done at edge_count=7.
2. P=16, S=5, a single-clock glitch to 1 at index 7 of a 0-bit: FIRST=6, LAST=10. sampled_valid at edge_count=11, sampled_data=0, noise_flag=1.
3. P=16, S=5, line=1 at indices 6..8 and 0 at indices 9..10: ones=3, so sampled_data=1 and noise_flag=1.
4. prescale=4 with SAMPLES_NO=3, then enable: cfg_error=1, edge_count stays 0, no sampled_valid or bit_done over 20 clocks. Changing prescale to 8 has no effect until a bit_restart pulse; after it, cfg_error=0 and normal counting.
5. P=8, bit_restart pulsed at edge_count=4: edge_count=0 next cycle, no vote for the aborted bit. The next vote lands 6 clocks after the restart.
6. rst asserted at edge_count=5 with sampled_data=1: all outputs 0 immediately. After release with enable high, counting restarts from 0 with P_lat re-latched.
